// File: rtl/writeback_merge_pkg.sv
// Shared core types for the writeback merge stage.
// Provides datapath widths and the writeback, bypass and completion packet formats.
package writeback_merge_pkg;

    localparam int SIZE_PHYSICAL_LOG   = 7;
    localparam int SIZE_DATA           = 32;
    localparam int SIZE_ACTIVELIST_LOG = 5;
    localparam int SIZE_SEQ            = 8;

    typedef struct packed {
        logic destValid;
        logic executed;
        logic mispredict;
    } wbFlags;

    typedef struct packed {
        logic [SIZE_SEQ-1:0]            seqNo;
        logic [SIZE_ACTIVELIST_LOG-1:0] alID;
        wbFlags                         flags;
        logic [SIZE_PHYSICAL_LOG-1:0]   phyDest;
        logic [SIZE_DATA-1:0]           destData;
        logic                           valid;
    } wbPkt;

    typedef struct packed {
        logic [SIZE_PHYSICAL_LOG-1:0] tag;
        logic [SIZE_DATA-1:0]         data;
        logic                         valid;
    } bypassPkt;

    typedef struct packed {
        logic [SIZE_SEQ-1:0]            seqNo;
        logic [SIZE_ACTIVELIST_LOG-1:0] alID;
        wbFlags                         flags;
        logic                           valid;
    } ctrlPkt;

endpackage

// File: rtl/writeback_merge_if.sv
// Bundle of the writeback merge lane inputs and PRF/bypass/completion outputs.
//   master : producer/consumer side (execution lanes, PRF, issue queue, active list)
//   slave  : the writeback_merge block
interface writeback_merge_if;
    import writeback_merge_pkg::*;

    wbPkt                         aluPacket_i;
    wbPkt                         lsuPacket_i;
    logic                         lsuReady_o;
    logic                         prfWrEn_o;
    logic [SIZE_PHYSICAL_LOG-1:0] prfWrAddr_o;
    logic [SIZE_DATA-1:0]         prfWrData_o;
    bypassPkt                     bypassPacket_o;
    ctrlPkt                       ctrlPacket_o;

    modport master (
        output aluPacket_i, lsuPacket_i,
        input  lsuReady_o, prfWrEn_o, prfWrAddr_o, prfWrData_o, bypassPacket_o, ctrlPacket_o
    );

    modport slave (
        input  aluPacket_i, lsuPacket_i,
        output lsuReady_o, prfWrEn_o, prfWrAddr_o, prfWrData_o, bypassPacket_o, ctrlPacket_o
    );

endinterface

// File: rtl/writeback_merge_wb_fifo.sv
// Holding buffer for long-latency lane packets.
//   clk, reset_n : clock, async active-low reset (pointers/occupancy only)
//   flush_i      : empties the buffer at the next edge
//   push_i/data_i: enqueue (ignored while full)
//   pop_i/data_o : dequeue; data_o is the current head
//   full_o/empty_o: registered-occupancy status
module wb_fifo
    import writeback_merge_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush_i,
    input  logic push_i,
    input  logic pop_i,
    input  wbPkt data_i,
    output wbPkt data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q;
    wbPkt            mem_q [Depth];
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Depth is a power of two, so pointer wrap is plain overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CntW'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/writeback_merge.sv
// Merges the single-cycle ALU lane and the long-latency LSU lane into one writeback
// port. ALU has strict priority; LSU packets wait in wb_fifo when they cannot go now.
//   clk, reset_n : clock, async active-low reset
//   flush_i      : squash buffered and staged packets
//   wb_if        : lane inputs, lsuReady_o, PRF write, bypass broadcast, completion
module writeback_merge
    import writeback_merge_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush_i,
    writeback_merge_if.slave  wb_if
);

    wbPkt out_q, out_d;
    wbPkt fifo_head;
    logic fifo_full, fifo_empty;
    logic alu_v, lsu_acc, push, pop;

    wb_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (flush_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (wb_if.lsuPacket_i),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign wb_if.lsuReady_o = !fifo_full;

    always_comb begin
        alu_v   = wb_if.aluPacket_i.valid;
        lsu_acc = wb_if.lsuPacket_i.valid && !fifo_full;
        // LSU goes straight through only when nothing older is waiting and ALU is idle.
        push    = lsu_acc && (alu_v || !fifo_empty);
        pop     = !alu_v && !fifo_empty;
        out_d   = '0;
        if (alu_v) begin
            out_d = wb_if.aluPacket_i;
        end else if (!fifo_empty) begin
            out_d = fifo_head;
        end else if (lsu_acc) begin
            out_d = wb_if.lsuPacket_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= '0;
        end else if (flush_i) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    always_comb begin
        wb_if.prfWrEn_o            = out_q.valid && out_q.flags.destValid;
        wb_if.prfWrAddr_o          = out_q.phyDest;
        wb_if.prfWrData_o          = out_q.destData;
        wb_if.bypassPacket_o       = '0;
        wb_if.bypassPacket_o.tag   = out_q.phyDest;
        wb_if.bypassPacket_o.data  = out_q.destData;
        wb_if.bypassPacket_o.valid = out_q.valid && out_q.flags.destValid;
        wb_if.ctrlPacket_o         = '0;
        wb_if.ctrlPacket_o.seqNo   = out_q.seqNo;
        wb_if.ctrlPacket_o.alID    = out_q.alID;
        wb_if.ctrlPacket_o.flags   = out_q.flags;
        wb_if.ctrlPacket_o.valid   = out_q.valid && out_q.flags.executed;
    end

endmodule

// File: tb/tb_writeback_merge.sv
// Self-checking bench for writeback_merge: queue-based reference model, per-cycle
// compare process, directed scenarios with literal expectations, then random traffic.
module tb_writeback_merge;
    import writeback_merge_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush_i = 1'b0;

    writeback_merge_if wb_if ();

    writeback_merge #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (flush_i),
        .wb_if   (wb_if)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_fail = 0;
    wbPkt lane_q[$];
    wbPkt exp_pkt = '0;
    wbPkt idle = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic wbPkt mk(input logic v, input int pd, input logic dv, input logic ex,
                                input int al, input int sq, input logic [31:0] d);
        wbPkt p;
        p                  = '0;
        p.valid            = v;
        p.phyDest          = pd[SIZE_PHYSICAL_LOG-1:0];
        p.flags.destValid  = dv;
        p.flags.executed   = ex;
        p.alID             = al[SIZE_ACTIVELIST_LOG-1:0];
        p.seqNo            = sq[SIZE_SEQ-1:0];
        p.destData         = d;
        return p;
    endfunction

    // Reference: accepted LSU packets join the lane queue in arrival order; each cycle the
    // ALU packet wins, otherwise the oldest queued LSU packet is written back.
    task automatic model_step(input wbPkt a, input wbPkt l, input logic fl);
        if (fl) begin
            lane_q.delete();
            exp_pkt = '0;
            return;
        end
        if (l.valid && lane_q.size() < DEPTH) lane_q.push_back(l);
        if (a.valid) exp_pkt = a;
        else if (lane_q.size() > 0) exp_pkt = lane_q.pop_front();
        else exp_pkt = '0;
    endtask

    task automatic cycle(input wbPkt a, input wbPkt l, input logic fl);
        wb_if.aluPacket_i = a;
        wb_if.lsuPacket_i = l;
        flush_i = fl;
        @(posedge clk);
        model_step(a, l, fl);
        #1;
    endtask

    always @(negedge clk) begin
        logic wr, cv;
        wr = exp_pkt.valid && exp_pkt.flags.destValid;
        cv = exp_pkt.valid && exp_pkt.flags.executed;
        check("lsuReady", 64'(wb_if.lsuReady_o), 64'(lane_q.size() < DEPTH));
        check("prfWrEn", 64'(wb_if.prfWrEn_o), 64'(wr));
        check("bypassValid", 64'(wb_if.bypassPacket_o.valid), 64'(wr));
        check("ctrlValid", 64'(wb_if.ctrlPacket_o.valid), 64'(cv));
        if (wr) begin
            check("prfWrAddr", 64'(wb_if.prfWrAddr_o), 64'(exp_pkt.phyDest));
            check("prfWrData", 64'(wb_if.prfWrData_o), 64'(exp_pkt.destData));
            check("bypassTag", 64'(wb_if.bypassPacket_o.tag), 64'(exp_pkt.phyDest));
            check("bypassData", 64'(wb_if.bypassPacket_o.data), 64'(exp_pkt.destData));
        end
        if (cv) begin
            check("ctrlAlID", 64'(wb_if.ctrlPacket_o.alID), 64'(exp_pkt.alID));
            check("ctrlSeqNo", 64'(wb_if.ctrlPacket_o.seqNo), 64'(exp_pkt.seqNo));
            check("ctrlFlags", 64'(wb_if.ctrlPacket_o.flags), 64'(exp_pkt.flags));
        end
    end

    initial begin
        wb_if.aluPacket_i = '0;
        wb_if.lsuPacket_i = '0;
        #1;
        check("rst_prfWrEn", 64'(wb_if.prfWrEn_o), 64'd0);
        check("rst_ctrlValid", 64'(wb_if.ctrlPacket_o.valid), 64'd0);
        check("rst_bypassValid", 64'(wb_if.bypassPacket_o.valid), 64'd0);
        check("rst_lsuReady", 64'(wb_if.lsuReady_o), 64'd1);
        #11;
        reset_n = 1'b1;

        // ALU-only stream 5,6,7
        for (int i = 0; i < 3; i++) begin
            cycle(mk(1, 5 + i, 1, 1, i, i, 32'h100 + i), idle, 0);
            check("alu_stream_en", 64'(wb_if.prfWrEn_o), 64'd1);
            check("alu_stream_addr", 64'(wb_if.prfWrAddr_o), 64'(5 + i));
        end
        cycle(idle, idle, 0);
        check("alu_stream_end", 64'(wb_if.prfWrEn_o), 64'd0);

        // Same-cycle ALU 10 and LSU 11
        cycle(mk(1, 10, 1, 1, 1, 1, 32'hA), mk(1, 11, 1, 1, 2, 2, 32'hB), 0);
        check("both_first", 64'(wb_if.prfWrAddr_o), 64'd10);
        cycle(idle, idle, 0);
        check("both_second_en", 64'(wb_if.prfWrEn_o), 64'd1);
        check("both_second", 64'(wb_if.prfWrAddr_o), 64'd11);

        // ALU busy 6 cycles, LSU pushing every cycle
        for (int i = 0; i < 6; i++) begin
            cycle(mk(1, 30 + i, 1, 1, i, i, 32'h300 + i), mk(1, 20 + i, 1, 1, i, i, 32'h200 + i), 0);
            if (i == 3) check("full_ready_low", 64'(wb_if.lsuReady_o), 64'd0);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(idle, idle, 0);
            check("drain_addr", 64'(wb_if.prfWrAddr_o), 64'(20 + i));
        end
        cycle(idle, idle, 0);
        check("drain_done", 64'(wb_if.prfWrEn_o), 64'd0);

        // Flush with 3 buffered
        for (int i = 0; i < 3; i++)
            cycle(mk(1, 50 + i, 1, 1, 0, 0, 32'h0), mk(1, 60 + i, 1, 1, 0, 0, 32'h0), 0);
        cycle(idle, idle, 1);
        check("flush_prfWrEn", 64'(wb_if.prfWrEn_o), 64'd0);
        check("flush_ctrlValid", 64'(wb_if.ctrlPacket_o.valid), 64'd0);
        check("flush_bypassValid", 64'(wb_if.bypassPacket_o.valid), 64'd0);
        check("flush_lsuReady", 64'(wb_if.lsuReady_o), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(idle, idle, 0);
            check("flush_no_stale", 64'(wb_if.prfWrEn_o), 64'd0);
        end

        // destValid=0, executed=1
        cycle(mk(1, 9, 0, 1, 13, 7, 32'h55), idle, 0);
        check("nodest_prfWrEn", 64'(wb_if.prfWrEn_o), 64'd0);
        check("nodest_ctrlValid", 64'(wb_if.ctrlPacket_o.valid), 64'd1);
        check("nodest_alID", 64'(wb_if.ctrlPacket_o.alID), 64'd13);

        // Async reset with 2 buffered
        cycle(mk(1, 40, 1, 1, 0, 0, 32'h0), mk(1, 42, 1, 1, 0, 0, 32'h0), 0);
        cycle(mk(1, 41, 1, 1, 0, 0, 32'h0), mk(1, 43, 1, 1, 0, 0, 32'h0), 0);
        wb_if.aluPacket_i = '0;
        wb_if.lsuPacket_i = '0;
        #2;
        reset_n = 1'b0;
        lane_q.delete();
        exp_pkt = '0;
        #1;
        check("arst_prfWrEn", 64'(wb_if.prfWrEn_o), 64'd0);
        check("arst_ctrlValid", 64'(wb_if.ctrlPacket_o.valid), 64'd0);
        check("arst_lsuReady", 64'(wb_if.lsuReady_o), 64'd1);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(idle, idle, 0);
            check("arst_no_write", 64'(wb_if.prfWrEn_o), 64'd0);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            wbPkt a, l;
            logic fl;
            a = mk(1'($urandom_range(0, 99) < 45), int'($urandom_range(0, 127)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                   int'($urandom_range(0, 31)), int'($urandom_range(0, 255)), $urandom);
            l = mk(1'($urandom_range(0, 99) < 60), int'($urandom_range(0, 127)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                   int'($urandom_range(0, 31)), int'($urandom_range(0, 255)), $urandom);
            fl = 1'($urandom_range(0, 99) < 3);
            cycle(a, l, fl);
        end
        for (int i = 0; i < 6; i++) cycle(idle, idle, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
